// File: rtl/booth16_multiplier.sv
// Sequential signed 64x64 -> 128 multiplier using 16 radix-16 Booth steps.
// Operands are latched on op_start; one Booth step is retired per clock.
module booth16_multiplier (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         op_start,
  input  logic         op_clear,
  input  logic [63:0]  multiplicand,
  input  logic [63:0]  multiplier,
  output logic         op_done,
  output logic [127:0] result
);

  localparam int unsigned OP_W   = 64;
  localparam int unsigned PROD_W = 2 * OP_W;
  localparam int unsigned PART_W = OP_W + 4;
  localparam int unsigned SUM_W  = PROD_W + 4;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [OP_W-1:0]     reg_multiplicand;
  logic [OP_W:0]       reg_multiplier;
  logic [PROD_W-1:0]   product;
  logic [CNT_W-1:0]    counter;

  logic [4:0]          window;
  logic signed [4:0]   digit;
  logic signed [4:0]   digit_abs;
  logic                digit_neg;
  logic [PART_W-1:0]   a_ext;
  logic [PART_W-1:0]   mag_mult;
  logic [PART_W-1:0]   partial;
  logic [SUM_W-1:0]    step_sum;
  logic [PROD_W-1:0]   step_product;

  // Booth digit from the 5-bit window: -8*w4 + 4*w3 + 2*w2 + w1 + w0
  always_comb begin
    window    = reg_multiplier[4:0];
    digit     = $signed({window[4], window[4:1]}) + $signed({4'b0000, window[0]});
    digit_neg = digit[4];
    digit_abs = digit_neg ? 5'(-digit) : digit;
  end

  // Step datapath: |d|*A via shifts/adds in 68 bits, so 8*A never wraps
  always_comb begin
    a_ext = {{4{reg_multiplicand[OP_W-1]}}, reg_multiplicand};
    case (digit_abs[3:0])
      4'd1:    mag_mult = a_ext;
      4'd2:    mag_mult = a_ext << 1;
      4'd3:    mag_mult = a_ext + (a_ext << 1);
      4'd4:    mag_mult = a_ext << 2;
      4'd5:    mag_mult = a_ext + (a_ext << 2);
      4'd6:    mag_mult = (a_ext << 1) + (a_ext << 2);
      4'd7:    mag_mult = (a_ext << 3) - a_ext;
      4'd8:    mag_mult = a_ext << 3;
      default: mag_mult = '0;
    endcase
    partial      = digit_neg ? (~mag_mult + PART_W'(1)) : mag_mult;
    step_sum     = {{4{product[PROD_W-1]}}, product} + {partial, {OP_W{1'b0}}};
    step_product = step_sum[SUM_W-1:4];
  end

  // Control FSM with operand, product and counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      counter          <= '0;
      product          <= '0;
      reg_multiplicand <= '0;
      reg_multiplier   <= '0;
      op_done          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (op_clear) begin
            counter          <= '0;
            product          <= '0;
            reg_multiplicand <= '0;
            reg_multiplier   <= '0;
            op_done          <= 1'b0;
          end else if (op_start) begin
            reg_multiplicand <= multiplicand;
            reg_multiplier   <= {multiplier, 1'b0};
            product          <= '0;
            counter          <= '0;
            op_done          <= 1'b0;
            state            <= EXEC;
          end
        end
        EXEC: begin
          if (op_clear) begin
            counter          <= '0;
            product          <= '0;
            reg_multiplicand <= '0;
            reg_multiplier   <= '0;
            op_done          <= 1'b0;
            state            <= IDLE;
          end else begin
            product        <= step_product;
            reg_multiplier <= {{4{reg_multiplier[OP_W]}}, reg_multiplier[OP_W:4]};
            counter        <= counter + CNT_W'(1);
            if (counter == CNT_W'(15)) begin
              state   <= DONE;
              op_done <= 1'b1;
            end
          end
        end
        DONE: begin
          if (op_clear) begin
            counter          <= '0;
            product          <= '0;
            reg_multiplicand <= '0;
            reg_multiplier   <= '0;
            op_done          <= 1'b0;
            state            <= IDLE;
          end else if (op_start) begin
            reg_multiplicand <= multiplicand;
            reg_multiplier   <= {multiplier, 1'b0};
            product          <= '0;
            counter          <= '0;
            op_done          <= 1'b0;
            state            <= EXEC;
          end
        end
        default: begin
          state   <= IDLE;
          op_done <= 1'b0;
        end
      endcase
    end
  end

  // Product is only visible while the result is final
  assign result = (state == DONE) ? product : '0;

endmodule

// File: tb/tb_booth16_multiplier.sv
// Self-checking bench for booth16_multiplier: exact-product model plus directed vectors.
module tb_booth16_multiplier;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         op_start = 1'b0;
  logic         op_clear = 1'b0;
  logic [63:0]  multiplicand = '0;
  logic [63:0]  multiplier = '0;
  logic         op_done;
  logic [127:0] result;

  int checks = 0;
  int failures = 0;

  booth16_multiplier dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .op_start     (op_start),
    .op_clear     (op_clear),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .op_done      (op_done),
    .result       (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Behavioural model: busy for 17 edges after an accepted start, then shows A*B
  logic               m_active = 1'b0;
  logic               m_done = 1'b0;
  int                 m_left = 0;
  logic signed [127:0] m_sa = '0;
  logic signed [127:0] m_sb = '0;
  logic [127:0]       m_prod = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_left   = 0;
      m_prod   = '0;
    end else if (op_clear) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_prod   = '0;
    end else if (!m_active && op_start) begin
      m_sa     = {{64{multiplicand[63]}}, multiplicand};
      m_sb     = {{64{multiplier[63]}}, multiplier};
      m_prod   = m_sa * m_sb;
      m_active = 1'b1;
      m_left   = 16;
      m_done   = 1'b0;
    end else if (m_active) begin
      m_left--;
      if (m_left == 0) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end
  end

  // Per-cycle compare of DUT outputs against the model
  always @(posedge clk) begin
    #1;
    chk("cyc_op_done", 128'(op_done), 128'(m_done));
    chk("cyc_result", result, m_done ? m_prod : 128'd0);
  end

  // Start an op; optionally re-pulse start or assert clear at a given edge count.
  // n returns the edge count at which op_done was first seen (0 if never).
  task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                        input int again_at, input int clear_at, input int max_edges,
                        output int n, output logic done_after_1);
    multiplicand = a;
    multiplier   = b;
    op_start     = 1'b1;
    n            = 0;
    done_after_1 = 1'b0;
    for (int i = 1; i <= max_edges; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) done_after_1 = op_done;
      if (op_done) begin
        n = i;
        break;
      end
      if (i == 1) op_start = 1'b0;
      if (i == again_at) op_start = 1'b1;
      if (again_at != 0 && i == again_at + 1) op_start = 1'b0;
      if (i == clear_at) op_clear = 1'b1;
      if (clear_at != 0 && i == clear_at + 1) op_clear = 1'b0;
    end
    op_start = 1'b0;
    op_clear = 1'b0;
  endtask

  int   n;
  logic d1;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_op_done", 128'(op_done), 128'd0);
    chk("reset_result", result, 128'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Test 1: 3*5, latency and hold
    run_op(64'd3, 64'd5, 0, 0, 40, n, d1);
    chk("t1_latency", 128'(n), 128'd17);
    chk("t1_result", result, 128'd15);
    repeat (4) @(posedge clk);
    #1;
    chk("t1_hold_done", 128'(op_done), 128'd1);
    chk("t1_hold_result", result, 128'd15);

    // Test 2: sign handling with B = -1
    run_op(64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 40, n, d1);
    chk("t2a_latency", 128'(n), 128'd17);
    chk("t2a_result", result, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF);
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 40, n, d1);
    chk("t2b_result", result, 128'hFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0001);

    // Test 3: most-negative squared
    run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, 0, 40, n, d1);
    chk("t3_latency", 128'(n), 128'd17);
    chk("t3_result", result, 128'h4000_0000_0000_0000_0000_0000_0000_0000);

    // Test 4: start ignored in EXEC, then clear aborts an op
    run_op(64'd3, 64'd5, 5, 0, 40, n, d1);
    chk("t4_restart_latency", 128'(n), 128'd17);
    chk("t4_restart_result", result, 128'd15);
    run_op(64'd11, 64'd13, 0, 8, 30, n, d1);
    chk("t4_clear_never_done", 128'(n), 128'd0);
    chk("t4_clear_result", result, 128'd0);

    // Test 5: restart from DONE, then start+clear together in DONE
    run_op(64'd3, 64'd5, 0, 0, 40, n, d1);
    chk("t5_first_result", result, 128'd15);
    run_op(-64'sd7, 64'd9, 0, 0, 40, n, d1);
    chk("t5_done_drop", 128'(d1), 128'd0);
    chk("t5_latency", 128'(n), 128'd17);
    chk("t5_result", result, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFC1);
    op_start = 1'b1;
    op_clear = 1'b1;
    @(posedge clk);
    #1;
    op_start = 1'b0;
    op_clear = 1'b0;
    chk("t5_clear_wins_done", 128'(op_done), 128'd0);
    chk("t5_clear_wins_result", result, 128'd0);
    repeat (20) @(posedge clk);
    #1;
    chk("t5_no_new_op", 128'(op_done), 128'd0);

    // Test 6: async reset mid-EXEC, then a fresh op
    run_op(64'd3, 64'd5, 0, 0, 40, n, d1);
    multiplicand = 64'd5;
    multiplier   = 64'd7;
    op_start     = 1'b1;
    @(posedge clk);
    #1;
    op_start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_reset_op_done", 128'(op_done), 128'd0);
    chk("t6_reset_result", result, 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("t6_no_done_after_reset", 128'(op_done), 128'd0);
    run_op(-64'sd2, -64'sd3, 0, 0, 40, n, d1);
    chk("t6_latency", 128'(n), 128'd17);
    chk("t6_result", result, 128'd6);

    repeat (2) @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
